// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared pipeline types and constants for hazard control
//   state_e    : hazard FSM state (RUN = 1'b0, STALL = 1'b1)
//   PIPE_REG_W : default register-address width
//   X0         : register address 0, never a real dependency
package hazard_stall_unit_pkg;

    localparam int PIPE_REG_W = 5;

    localparam logic [PIPE_REG_W-1:0] X0 = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall and taken-branch flush control for the 5-stage pipeline
//   clock, reset                  : rising-edge clock, synchronous active-high reset
//   idex_memRead, idex_rd         : load in EX and its destination register
//   ifid_rs1, ifid_rs2, ifid_useRs2 : source registers of the instruction in ID
//   branch_taken                  : branch in MEM resolved taken this cycle
//   ctrl_sel                      : control-mux selector, 0 inserts a bubble into ID/EX
//   pc_write, ifid_write          : PC and IF/ID write enables
//   ifid_flush, idex_flush, exmem_flush : pipeline register clears
//   stall_count, flush_count      : wrapping bubble and flush event counters
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W        = PIPE_REG_W,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idex_memRead,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_useRs2,
    input  logic             branch_taken,
    output logic             ctrl_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int CW = $clog2(STALL_CYCLES + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load_use;
    logic            bubble;

    assign load_use = idex_memRead && (idex_rd != REG_W'(X0)) &&
                      ((idex_rd == ifid_rs1) || (ifid_useRs2 && (idex_rd == ifid_rs2)));

    // A taken branch overrides everything: the dependent instruction is flushed,
    // so any pending stall is dropped. STALL ignores load_use until cnt runs out.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bubble      = 1'b0;
        ctrl_sel    = 1'b1;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (branch_taken) begin
            ctrl_sel    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
        end else if (state_q == STALL) begin
            bubble  = 1'b1;
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? RUN : STALL;
        end else if (load_use) begin
            bubble = 1'b1;
            if (STALL_CYCLES > 1) begin
                state_d = STALL;
                cnt_d   = CW'(STALL_CYCLES - 1);
            end
        end
        if (bubble) begin
            ctrl_sel   = 1'b0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            stall_count <= '0;
        else if (bubble)
            stall_count <= stall_count + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            flush_count <= '0;
        else if (branch_taken)
            flush_count <= flush_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed checks of hazard_stall_unit with 1-cycle and 3-cycle stall variants
module tb_hazard_stall_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       idex_memRead;
    logic [4:0] idex_rd;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       ifid_useRs2;
    logic       branch_taken;

    logic        a_ctrl_sel, a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush, a_exmem_flush;
    logic [15:0] a_stall_count, a_flush_count;
    logic        b_ctrl_sel, b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_exmem_flush;
    logic [1:0]  b_stall_count, b_flush_count;

    int cmp = 0;
    int err = 0;

    always #5 clock = ~clock;

    hazard_stall_unit #(.REG_W(5), .STALL_CYCLES(1), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .idex_memRead(idex_memRead), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_useRs2(ifid_useRs2),
        .branch_taken(branch_taken), .ctrl_sel(a_ctrl_sel), .pc_write(a_pc_write),
        .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush),
        .exmem_flush(a_exmem_flush), .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    hazard_stall_unit #(.REG_W(5), .STALL_CYCLES(3), .CNT_W(2)) u_b (
        .clock(clock), .reset(reset), .idex_memRead(idex_memRead), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_useRs2(ifid_useRs2),
        .branch_taken(branch_taken), .ctrl_sel(b_ctrl_sel), .pc_write(b_pc_write),
        .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush),
        .exmem_flush(b_exmem_flush), .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic use2, input logic br);
        idex_memRead = mr;
        idex_rd      = rd;
        ifid_rs1     = rs1;
        ifid_rs2     = rs2;
        ifid_useRs2  = use2;
        branch_taken = br;
        #1;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1'b1;
        repeat (3) cyc();
        cmp++; if (a_ctrl_sel !== 1'b1) begin err++; $display("FAIL reset_ctrl_sel got %b want 1", a_ctrl_sel); end
        cmp++; if (a_pc_write !== 1'b1) begin err++; $display("FAIL reset_pc_write got %b want 1", a_pc_write); end
        cmp++; if (b_ifid_write !== 1'b1) begin err++; $display("FAIL reset_ifid_write got %b want 1", b_ifid_write); end
        cmp++; if ({b_ifid_flush, b_idex_flush, b_exmem_flush} !== 3'b000) begin err++; $display("FAIL reset_flushes got %b want 000", {b_ifid_flush, b_idex_flush, b_exmem_flush}); end
        cmp++; if (a_stall_count !== 16'd0) begin err++; $display("FAIL reset_stall_count got %0d want 0", a_stall_count); end
        cmp++; if (a_flush_count !== 16'd0) begin err++; $display("FAIL reset_flush_count got %0d want 0", a_flush_count); end
        reset = 1'b0;
    endtask

    task automatic test_stall1();
        do_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
        cmp++; if ({a_ctrl_sel, a_pc_write, a_ifid_write} !== 3'b000) begin err++; $display("FAIL s1_bubble got %b want 000", {a_ctrl_sel, a_pc_write, a_ifid_write}); end
        cmp++; if ({a_ifid_flush, a_idex_flush, a_exmem_flush} !== 3'b000) begin err++; $display("FAIL s1_noflush got %b want 000", {a_ifid_flush, a_idex_flush, a_exmem_flush}); end
        cyc();
        quiet();
        cmp++; if ({a_ctrl_sel, a_pc_write} !== 2'b11) begin err++; $display("FAIL s1_resume got %b want 11", {a_ctrl_sel, a_pc_write}); end
        cmp++; if (a_stall_count !== 16'd1) begin err++; $display("FAIL s1_stall_count got %0d want 1", a_stall_count); end
    endtask

    task automatic test_stall3();
        do_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
        cmp++; if ({b_ctrl_sel, b_pc_write} !== 2'b00) begin err++; $display("FAIL s3_c1 got %b want 00", {b_ctrl_sel, b_pc_write}); end
        cyc();
        quiet();
        cmp++; if ({b_ctrl_sel, b_pc_write, b_ifid_write} !== 3'b000) begin err++; $display("FAIL s3_c2 got %b want 000", {b_ctrl_sel, b_pc_write, b_ifid_write}); end
        cmp++; if (a_ctrl_sel !== 1'b1) begin err++; $display("FAIL s1_c2_run got %b want 1", a_ctrl_sel); end
        cyc();
        cmp++; if ({b_ctrl_sel, b_pc_write} !== 2'b00) begin err++; $display("FAIL s3_c3 got %b want 00", {b_ctrl_sel, b_pc_write}); end
        cyc();
        cmp++; if ({b_ctrl_sel, b_pc_write} !== 2'b11) begin err++; $display("FAIL s3_c4_run got %b want 11", {b_ctrl_sel, b_pc_write}); end
        cmp++; if (b_stall_count !== 2'd3) begin err++; $display("FAIL s3_stall_count got %0d want 3", b_stall_count); end
        cmp++; if (a_stall_count !== 16'd1) begin err++; $display("FAIL s1_stall_count_b got %0d want 1", a_stall_count); end
    endtask

    task automatic test_no_hazard();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cmp++; if (a_ctrl_sel !== 1'b1) begin err++; $display("FAIL nh_x0 got %b want 1", a_ctrl_sel); end
        drive(1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0);
        cmp++; if (a_pc_write !== 1'b1) begin err++; $display("FAIL nh_rs2_unused got %b want 1", a_pc_write); end
        drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0);
        cmp++; if (a_ctrl_sel !== 1'b1) begin err++; $display("FAIL nh_not_load got %b want 1", a_ctrl_sel); end
        drive(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0);
        cmp++; if ({a_ctrl_sel, a_pc_write} !== 2'b00) begin err++; $display("FAIL nh_rs2_used got %b want 00", {a_ctrl_sel, a_pc_write}); end
        cyc();
        quiet();
        cmp++; if (a_stall_count !== 16'd1) begin err++; $display("FAIL nh_stall_count got %0d want 1", a_stall_count); end
    endtask

    task automatic test_branch_priority();
        do_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1);
        cmp++; if ({b_ifid_flush, b_idex_flush, b_exmem_flush} !== 3'b111) begin err++; $display("FAIL bp_flushes got %b want 111", {b_ifid_flush, b_idex_flush, b_exmem_flush}); end
        cmp++; if ({b_ctrl_sel, b_pc_write, b_ifid_write} !== 3'b011) begin err++; $display("FAIL bp_ctrl got %b want 011", {b_ctrl_sel, b_pc_write, b_ifid_write}); end
        cyc();
        quiet();
        cmp++; if ({b_ctrl_sel, b_pc_write} !== 2'b11) begin err++; $display("FAIL bp_run got %b want 11", {b_ctrl_sel, b_pc_write}); end
        cmp++; if (b_flush_count !== 2'd1) begin err++; $display("FAIL bp_flush_count got %0d want 1", b_flush_count); end
        cmp++; if (b_stall_count !== 2'd0) begin err++; $display("FAIL bp_stall_count got %0d want 0", b_stall_count); end
    endtask

    task automatic test_branch_mid_stall();
        do_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        cmp++; if ({b_ifid_flush, b_idex_flush, b_exmem_flush, b_pc_write} !== 4'b1111) begin err++; $display("FAIL bm_flush got %b want 1111", {b_ifid_flush, b_idex_flush, b_exmem_flush, b_pc_write}); end
        cyc();
        quiet();
        cmp++; if ({b_ctrl_sel, b_pc_write} !== 2'b11) begin err++; $display("FAIL bm_run got %b want 11", {b_ctrl_sel, b_pc_write}); end
        cmp++; if (b_stall_count !== 2'd1) begin err++; $display("FAIL bm_stall_count got %0d want 1", b_stall_count); end
        cmp++; if (b_flush_count !== 2'd1) begin err++; $display("FAIL bm_flush_count got %0d want 1", b_flush_count); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
        cyc();
        quiet();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        cmp++; if ({b_ctrl_sel, b_pc_write} !== 2'b11) begin err++; $display("FAIL rm_run got %b want 11", {b_ctrl_sel, b_pc_write}); end
        cmp++; if ({b_stall_count, b_flush_count} !== 4'd0) begin err++; $display("FAIL rm_counters got %b want 0000", {b_stall_count, b_flush_count}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
        cyc();
        cmp++; if ({a_ctrl_sel, a_pc_write} !== 2'b00) begin err++; $display("FAIL bb_second got %b want 00", {a_ctrl_sel, a_pc_write}); end
        cyc();
        quiet();
        cmp++; if (a_stall_count !== 16'd2) begin err++; $display("FAIL bb_stall_count got %0d want 2", a_stall_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (2) begin
            drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
            cyc();
            quiet();
            repeat (2) cyc();
        end
        cmp++; if (b_stall_count !== 2'd2) begin err++; $display("FAIL wrap_stall_count got %0d want 2", b_stall_count); end
        repeat (5) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
            cyc();
        end
        quiet();
        cmp++; if (b_flush_count !== 2'd1) begin err++; $display("FAIL wrap_flush_count got %0d want 1", b_flush_count); end
        cmp++; if (a_flush_count !== 16'd5) begin err++; $display("FAIL wide_flush_count got %0d want 5", a_flush_count); end
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        test_reset();
        test_stall1();
        test_stall3();
        test_no_hazard();
        test_branch_priority();
        test_branch_mid_stall();
        test_reset_mid_stall();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
